bar_gen: RTL and testbench

BAR_GEN -- requirements
Module: bar_gen

---
 rtl/bar_gen.sv | 154 +++++++++++++++
 tb/tb_bar_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_gen.sv
// bar_gen -- produces batches of NUM_BARS pseudo-random bar heights for a downstream sorter.
//
// A 16-bit Galois LFSR (taps 16'hB400) supplies candidates. Each cycle in GEN takes
// lfsr[5:0] as the candidate, and the LFSR then advances. A zero candidate is rejected.
// An accepted candidate is presented on a valid/ready handshake. After NUM_BARS
// handshakes the block parks in DONE until the next start.
//
// Optional feature: define BAR_GEN_UNIQUE_EN to also reject heights already sent in the
// current batch. This adds one history register per slot. With the macro undefined,
// duplicates are allowed and there is no history storage.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a new batch (accepted in IDLE/DONE only)
//   seed_load  in   load seed into the LFSR (IDLE/DONE only; wins over start)
//   seed       in   seed value; 0 selects LFSR_SEED
//   bar_valid  out  bar_index/bar_height hold a valid bar
//   bar_ready  in   downstream accepts the current bar
//   bar_index  out  slot number of the current bar
//   bar_height out  height of the current bar (1..63)
//   busy       out  high in GEN and SEND
//   done       out  high after a complete batch until the next start or reset
module bar_gen #(
  parameter int unsigned NUM_BARS  = 5,
  parameter int unsigned HEIGHT_W  = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                seed_load,
  input  logic [15:0]         seed,
  output logic                bar_valid,
  input  logic                bar_ready,
  output logic [2:0]          bar_index,
  output logic [HEIGHT_W-1:0] bar_height,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StGen, StSend, StDone} state_e;

  localparam logic [15:0] Taps    = 16'hB400;
  localparam logic [2:0]  LastIdx = 3'(NUM_BARS - 1);

  state_e              r_state, w_state_next;
  logic [15:0]         r_lfsr, w_lfsr_next, w_lfsr_step;
  logic                r_bar_valid, w_bar_valid_next;
  logic [2:0]          r_bar_index, w_bar_index_next;
  logic [HEIGHT_W-1:0] r_bar_height, w_bar_height_next;
  logic [HEIGHT_W-1:0] w_cand;
  logic                w_dup;
  logic                w_cand_ok;

  // Bit 15 of the step result is set exactly when the XOR is applied. So a nonzero
  // state can never step to zero, and seed=0 is remapped below.
  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ Taps) : (r_lfsr >> 1);
  assign w_cand      = HEIGHT_W'(r_lfsr[5:0]);

`ifdef BAR_GEN_UNIQUE_EN
  logic [HEIGHT_W-1:0] r_hist [NUM_BARS];
  logic                w_hist_clr;
  logic                w_hist_wr;

  // Cleared entries hold 0. Because a zero candidate is rejected anyway, an empty
  // slot can never match.
  always_comb begin
    w_dup = 1'b0;
    for (int unsigned i = 0; i < NUM_BARS; i++) begin
      if (r_hist[i] == w_cand) w_dup = 1'b1;
    end
  end

  assign w_hist_clr = ((r_state == StIdle) || (r_state == StDone)) && start && !seed_load;
  assign w_hist_wr  = (r_state == StGen) && w_cand_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_BARS; i++) r_hist[i] <= '0;
    end else if (w_hist_clr) begin
      for (int unsigned i = 0; i < NUM_BARS; i++) r_hist[i] <= '0;
    end else if (w_hist_wr) begin
      r_hist[r_bar_index] <= w_cand;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_cand_ok = (r_lfsr[5:0] != 6'd0) && !w_dup;

  always_comb begin
    w_state_next      = r_state;
    w_lfsr_next       = r_lfsr;
    w_bar_valid_next  = r_bar_valid;
    w_bar_index_next  = r_bar_index;
    w_bar_height_next = r_bar_height;
    unique case (r_state)
      StIdle, StDone: begin
        // seed_load wins over start; a start in the same cycle is dropped.
        if (seed_load) begin
          w_lfsr_next = (seed == 16'h0000) ? LFSR_SEED : seed;
        end else if (start) begin
          w_bar_index_next = '0;
          w_state_next     = StGen;
        end
      end
      StGen: begin
        w_lfsr_next = w_lfsr_step;
        if (w_cand_ok) begin
          w_bar_height_next = w_cand;
          w_bar_valid_next  = 1'b1;
          w_state_next      = StSend;
        end
      end
      StSend: begin
        if (bar_ready) begin
          w_bar_valid_next = 1'b0;
          if (r_bar_index == LastIdx) begin
            w_state_next = StDone;
          end else begin
            w_bar_index_next = r_bar_index + 3'd1;
            w_state_next     = StGen;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_lfsr       <= LFSR_SEED;
      r_bar_valid  <= 1'b0;
      r_bar_index  <= '0;
      r_bar_height <= '0;
    end else begin
      r_state      <= w_state_next;
      r_lfsr       <= w_lfsr_next;
      r_bar_valid  <= w_bar_valid_next;
      r_bar_index  <= w_bar_index_next;
      r_bar_height <= w_bar_height_next;
    end
  end

  assign bar_valid  = r_bar_valid;
  assign bar_index  = r_bar_index;
  assign bar_height = r_bar_height;
  assign busy       = (r_state == StGen) || (r_state == StSend);
  assign done       = (r_state == StDone);

endmodule

// File: tb/tb_bar_gen.sv
// Self-checking bench for bar_gen: a transaction-level model plans each bar's height and
// GEN latency up front. A per-cycle compare process then checks all outputs against it.
module tb_bar_gen;
  localparam int          NB    = 5;
  localparam int          HW    = 7;
  localparam logic [15:0] SEED0 = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          seed_load = 1'b0;
  logic [15:0]   seed = 16'h0000;
  logic          bar_ready = 1'b0;
  logic          bar_valid;
  logic [2:0]    bar_index;
  logic [HW-1:0] bar_height;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int hs_q[$];
  int b1[$];

  always #5 clk = ~clk;

  bar_gen #(
    .NUM_BARS (NB),
    .HEIGHT_W (HW),
    .LFSR_SEED(SEED0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .bar_valid (bar_valid),
    .bar_ready (bar_ready),
    .bar_index (bar_index),
    .bar_height(bar_height),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // First accepted height from a given LFSR value (first slot, so no duplicate rule).
  function automatic int first_height(input logic [15:0] v);
    logic [15:0] l = v;
    for (int k = 0; k < 64; k++) begin
      if (l[5:0] != 6'd0) return int'(l[5:0]);
      l = lfsr_next(l);
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_lfsr = SEED0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_valid = 1'b0;
  int          m_slot = 0;
  int          m_height = 0;
  int          m_pending = 0;
  int          m_gen_left = 0;
  int          m_hist[NB];

  // Decide the whole next bar at once: its height and how many GEN cycles it costs.
  task automatic plan_slot();
    int cnt;
    int cand;
    bit ok;
    cnt = 0;
    cand = 0;
    ok = 1'b0;
    while (!ok && cnt < 100000) begin
      cand   = int'(m_lfsr[5:0]);
      m_lfsr = lfsr_next(m_lfsr);
      cnt++;
      ok = (cand != 0);
`ifdef BAR_GEN_UNIQUE_EN
      for (int i = 0; i < m_slot; i++) if (m_hist[i] == cand) ok = 1'b0;
`endif
    end
    m_gen_left = cnt;
    m_pending  = cand;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr = SEED0; m_busy = 0; m_done = 0; m_valid = 0;
      m_slot = 0; m_height = 0; m_gen_left = 0;
      for (int i = 0; i < NB; i++) m_hist[i] = 0;
    end else if (!m_busy) begin
      if (seed_load) begin
        m_lfsr = (seed == 16'h0) ? SEED0 : seed;
      end else if (start) begin
        m_done = 0; m_busy = 1; m_slot = 0;
        for (int i = 0; i < NB; i++) m_hist[i] = 0;
        plan_slot();
      end
    end else if (m_valid) begin
      if (bar_ready) begin
        m_valid = 0;
        if (m_slot == NB - 1) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_slot++;
          plan_slot();
        end
      end
    end else begin
      m_gen_left--;
      if (m_gen_left == 0) begin
        m_valid = 1; m_height = m_pending; m_hist[m_slot] = m_pending;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", int'(bar_valid), int'(m_valid));
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("index", int'(bar_index), m_slot);
      if (m_valid) check("height", int'(bar_height), m_height);
    end
  end

  always @(posedge clk) begin
    if (reset_n && bar_valid && bar_ready) hs_q.push_back(int'(bar_height));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin tick(1); n++; end
    check(name, int'(done), 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!bar_valid && n < budget) begin tick(1); n++; end
    check(name, int'(bar_valid), 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_valid"}, int'(bar_valid), 0);
    check({tag, "_index"}, int'(bar_index), 0);
    check({tag, "_height"}, int'(bar_height), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int n;
    // Pin the model's candidate rule with hand-derived values.
    check("model_first_acee1", first_height(SEED0), 33);
    check("model_second_e270", first_height(lfsr_next(SEED0)), 48);
    check("model_first_0040", first_height(16'h0040), 32);

    // Reset state.
    tick(3);
    check_reset_outs("rst");
    chk_en = 1'b1;
    reset_n = 1'b1;
    tick(1);

    // First batch with bar_ready held high.
    bar_ready = 1'b1;
    hs_q.delete();
    do_start();
    wait_done(200, "b1_done");
    check("b1_count", hs_q.size(), NB);
    if (hs_q.size() >= 2) begin
      check("b1_h0", hs_q[0], 33);
      check("b1_h1", hs_q[1], 48);
    end
    b1 = hs_q;

    // seed=0 in IDLE restores the reset sequence.
    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(1);
    seed = 16'h1234; seed_load = 1'b1; tick(1);
    seed = 16'h0000; tick(1);
    seed_load = 1'b0;
    hs_q.delete();
    do_start();
    wait_done(200, "b2_done");
    check("b2_count", hs_q.size(), NB);
    for (int i = 0; i < b1.size() && i < hs_q.size(); i++) check("b2_same_seq", hs_q[i], b1[i]);

    // seed_load and start together in DONE: seed loads, start is dropped.
    seed = 16'h0040; seed_load = 1'b1; start = 1'b1; tick(1);
    seed_load = 1'b0; start = 1'b0;
    check("prio_done", int'(done), 1);
    check("prio_busy", int'(busy), 0);

    // Seed with zero low bits: first GEN cycle rejected.
    bar_ready = 1'b0;
    do_start();
    check("rej_gen1_valid", int'(bar_valid), 0);
    check("rej_gen1_busy", int'(busy), 1);
    tick(1);
    check("rej_gen2_valid", int'(bar_valid), 0);
    tick(1);
    check("rej_valid", int'(bar_valid), 1);
    check("rej_height", int'(bar_height), 32);

    // Backpressure: hold for 10 cycles, then a single handshake.
    tick(10);
    check("hold_valid", int'(bar_valid), 1);
    check("hold_index", int'(bar_index), 0);
    check("hold_height", int'(bar_height), 32);
    bar_ready = 1'b1; tick(1); bar_ready = 1'b0;
    check("hs_clears_valid", int'(bar_valid), 0);
    wait_valid(100, "slot1_valid");
    check("slot1_index", int'(bar_index), 1);
    bar_ready = 1'b1; tick(1); bar_ready = 1'b0;
    wait_valid(100, "slot2_valid");
    check("slot2_index", int'(bar_index), 2);

    // Asynchronous reset mid-batch.
    #3 reset_n = 1'b0;
    #1 check_reset_outs("arst");
    #2 reset_n = 1'b1;
    tick(1);
    bar_ready = 1'b1;
    hs_q.delete();
    do_start();
    check("restart_index", int'(bar_index), 0);
    wait_done(200, "b3_done");
    check("b3_count", hs_q.size(), NB);
    if (hs_q.size() > 0) check("b3_h0", hs_q[0], 33);

    // Randomised batches with random seeds, backpressure and ignored requests.
    for (int b = 0; b < 20; b++) begin
      seed = 16'($urandom); seed_load = 1'b1; tick(1); seed_load = 1'b0;
      hs_q.delete();
      do_start();
      n = 0;
      while (!done && n < 3000) begin
        bar_ready = ($urandom_range(0, 3) != 0);
        start     = m_busy && !m_valid && ($urandom_range(0, 7) == 0);
        seed_load = m_busy && !m_valid && ($urandom_range(0, 7) == 0);
        seed      = 16'($urandom);
        tick(1);
        n++;
      end
      start = 1'b0; seed_load = 1'b0; bar_ready = 1'b0;
      check("rnd_done", int'(done), 1);
      check("rnd_count", hs_q.size(), NB);
      for (int i = 0; i < hs_q.size(); i++) begin
        check("rnd_range", int'(hs_q[i] >= 1 && hs_q[i] <= 63), 1);
`ifdef BAR_GEN_UNIQUE_EN
        for (int j = 0; j < i; j++) check("rnd_unique", int'(hs_q[i] != hs_q[j]), 1);
`endif
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
